// File: rtl/gadget_sequencer.sv
// gadget_sequencer: per-trace phase sequencer for the masked gadget.
// Optional LFSR randomness source: define LFSR_RAND_EN.
module gadget_sequencer #(
   parameter int          IN_SIZE       = 4,
   parameter int          OUT_SIZE      = 1,
   parameter int          SETTLE_CYCLES = 4,
   parameter logic [7:0]  SEED          = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [15:0]            n_traces,
   input  logic                   sh_valid,
   output logic                   sh_ready,
   input  logic [1:0]             sh_data,
   input  logic [1:0]             rand_in,
   output logic [IN_SIZE-1:0]     gadget_in,
   input  logic [OUT_SIZE-1:0]    gadget_out,
   output logic                   trig,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [16+OUT_SIZE-1:0] res_data,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE, CLEAR, RAND, SHARE, SETTLE, CAPTURE, REPORT, FIN
   } state_t;

   state_t        state;
   logic [15:0]   count;
   logic [15:0]   trace_idx;
   logic [CW-1:0] cnt;
   logic [1:0]    rnd;

`ifdef LFSR_RAND_EN
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   logic [7:0] lfsr;
   logic       unused_rand;
   assign unused_rand = ^rand_in;
   assign rnd = lfsr[1:0];
`else
   assign rnd = rand_in;
`endif

   // Phase sequencer; every output is updated on the edge entering its state
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         trace_idx <= '0;
         cnt       <= '0;
         gadget_in <= '0;
         trig      <= 1'b0;
         sh_ready  <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef LFSR_RAND_EN
         lfsr      <= SEED_EFF;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (n_traces == 16'd0) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     count     <= n_traces;
                     trace_idx <= '0;
                     gadget_in <= '0;
                     state     <= CLEAR;
                  end
               end
            end
            CLEAR: begin
               gadget_in <= IN_SIZE'({rnd, 2'b00});
`ifdef LFSR_RAND_EN
               lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
`endif
               state <= RAND;
            end
            RAND: begin
               sh_ready <= 1'b1;
               state    <= SHARE;
            end
            SHARE: begin
               if (sh_valid) begin
                  gadget_in[1:0] <= sh_data;
                  sh_ready       <= 1'b0;
                  trig           <= 1'b1;
                  cnt            <= '0;
                  state          <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                  trig  <= 1'b0;
                  state <= CAPTURE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               res_data  <= {trace_idx, gadget_out};
               res_valid <= 1'b1;
               state     <= REPORT;
            end
            REPORT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (trace_idx + 16'd1 == count) begin
                     gadget_in <= '0;
                     done      <= 1'b1;
                     state     <= FIN;
                  end else begin
                     trace_idx <= trace_idx + 16'd1;
                     gadget_in <= '0;
                     state     <= CLEAR;
                  end
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gadget_sequencer.sv
// tb_gadget_sequencer: directed bench for gadget_sequencer.
// Gadget stand-in returns the XOR of its input vector.
module tb_gadget_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] n_traces;
   logic        sh_valid;
   logic        sh_ready;
   logic [1:0]  sh_data;
   logic [1:0]  rand_in;
   logic [3:0]  gadget_in;
   logic [0:0]  gadget_out;
   logic        trig;
   logic        res_valid;
   logic        res_ready;
   logic [16:0] res_data;
   logic        busy;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] m_lfsr;

   always #5 clk = ~clk;

   assign gadget_out = ^gadget_in;

   gadget_sequencer #(
      .IN_SIZE(4), .OUT_SIZE(1), .SETTLE_CYCLES(4), .SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .n_traces(n_traces),
      .sh_valid(sh_valid), .sh_ready(sh_ready), .sh_data(sh_data),
      .rand_in(rand_in), .gadget_in(gadget_in), .gadget_out(gadget_out),
      .trig(trig), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      logic [7:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 8'b1011_1000;
      return n;
   endfunction

   task automatic next_r(output logic [1:0] r);
`ifdef LFSR_RAND_EN
      r = m_lfsr[1:0];
      m_lfsr = lfsr_step(m_lfsr);
`else
      r = rand_in;
`endif
   endtask

   task automatic start_campaign(input logic [15:0] n);
      @(negedge clk);
      n_traces = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_gi"}, 32'(gadget_in), 32'h0);
      check({tag, "_trig"}, 32'(trig), 32'h0);
      check({tag, "_shr"}, 32'(sh_ready), 32'h0);
      check({tag, "_rv"}, 32'(res_valid), 32'h0);
      check({tag, "_rd"}, 32'(res_data), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_done"}, 32'(done), 32'h0);
   endtask

   initial begin
      logic [1:0]  r;
      logic [3:0]  exp_gi;
      logic [16:0] exp_rd;
      int          trig_cnt;
      int          p;
      int          t;
      logic        done_seen;

      rst = 1'b1;
      start = 1'b0;
      n_traces = '0;
      sh_valid = 1'b0;
      sh_data = 2'b10;
      rand_in = 2'b11;
      res_ready = 1'b0;
      m_lfsr = 8'hA5;
      r = 2'b00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_zero("idle");

      // three back-to-back traces, no stalls
      sh_valid = 1'b1;
      res_ready = 1'b1;
      trig_cnt = 0;
      start_campaign(16'd3);
      for (int k = 0; k < 27; k++) begin
         p = k % 9;
         t = k / 9;
         if (p == 1) next_r(r);
`ifdef LFSR_RAND_EN
         if (k == 1) check("lfsr_r0", 32'(gadget_in[3:2]), 32'h1);
`endif
         if (p == 0) exp_gi = 4'b0000;
         else if (p <= 2) exp_gi = {r, 2'b00};
         else exp_gi = {r, 2'b10};
         check($sformatf("gi_k%0d", k), 32'(gadget_in), 32'(exp_gi));
         check($sformatf("trig_k%0d", k), 32'(trig),
               32'(p >= 3 && p <= 6));
         check($sformatf("shr_k%0d", k), 32'(sh_ready), 32'(p == 2));
         check($sformatf("rv_k%0d", k), 32'(res_valid), 32'(p == 8));
         check($sformatf("busy_k%0d", k), 32'(busy), 32'h1);
         if (p == 8) begin
            exp_rd = {16'(t), ^exp_gi};
            check($sformatf("rd_t%0d", t), 32'(res_data), 32'(exp_rd));
         end
         if (trig) trig_cnt++;
         @(negedge clk);
      end
      check("trig_total", 32'(trig_cnt), 32'd12);
      check("fin_done", 32'(done), 32'h1);
      check("fin_busy", 32'(busy), 32'h1);
      check("fin_gi", 32'(gadget_in), 32'h0);
      @(negedge clk);
      check("post_done", 32'(done), 32'h0);
      check("post_busy", 32'(busy), 32'h0);

      // stall in SHARE for 7 cycles, then in REPORT for 5 cycles
      sh_valid = 1'b0;
      res_ready = 1'b0;
      start_campaign(16'd1);
      check("st_clear_gi", 32'(gadget_in), 32'h0);
      @(negedge clk);
      next_r(r);
      exp_gi = {r, 2'b10};
      exp_rd = {16'd0, ^exp_gi};
      for (int k = 2; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("st_shr_k%0d", k), 32'(sh_ready), 32'h1);
         check($sformatf("st_trig_k%0d", k), 32'(trig), 32'h0);
         check($sformatf("st_gi_k%0d", k), 32'(gadget_in),
               32'({r, 2'b00}));
      end
      sh_valid = 1'b1;
      @(negedge clk);
      sh_valid = 1'b0;
      check("st_settle_trig", 32'(trig), 32'h1);
      check("st_settle_gi", 32'(gadget_in), 32'(exp_gi));
      repeat (5) @(negedge clk);
      for (int k = 14; k <= 18; k++) begin
         check($sformatf("st_rv_k%0d", k), 32'(res_valid), 32'h1);
         check($sformatf("st_rd_k%0d", k), 32'(res_data), 32'(exp_rd));
         check($sformatf("st_rtrig_k%0d", k), 32'(trig), 32'h0);
         if (k < 18) @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("st_done", 32'(done), 32'h1);
      check("st_rv_off", 32'(res_valid), 32'h0);
      @(negedge clk);
      check("st_idle", 32'(busy), 32'h0);

      // zero-length campaign
      start_campaign(16'd0);
      check("z_done", 32'(done), 32'h1);
      check("z_rv", 32'(res_valid), 32'h0);
      check("z_busy", 32'(busy), 32'h1);
      @(negedge clk);
      check("z_done_off", 32'(done), 32'h0);
      check("z_busy_off", 32'(busy), 32'h0);

      // reset during SETTLE of the second trace
      sh_valid = 1'b1;
      res_ready = 1'b1;
      start_campaign(16'd2);
      repeat (13) @(negedge clk);
      check("rs_trig", 32'(trig), 32'h1);
      check("rs_rd", 32'(res_data[16:1]), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_lfsr = 8'hA5;
      check_zero("rs");
      done_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      check("rs_no_done", 32'(done_seen), 32'h0);
      check("rs_busy", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
